// File: rtl/rectangle_pkg.sv
// rectangle_pkg
//   Shared constants for the RECTANGLE-128 round sequencer: round count,
//   round-constant width and seed, FSM state encoding, and the round-constant
//   LFSR update rule used by both the sequencer and the key-schedule datapath.
package rectangle_pkg;

  localparam int unsigned  NUM_ROUNDS = 25;
  localparam int unsigned  RW         = 5;
  localparam logic [RW-1:0] RC_INIT   = 5'h01;

  // Legacy-compatible 2-bit state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Round-constant LFSR step: shift left, feedback = rc[4] ^ rc[2]
  function automatic logic [RW-1:0] rc_next(input logic [RW-1:0] rc);
    return {rc[RW-2:0], rc[RW-1] ^ rc[RW-3]};
  endfunction

endpackage

// File: rtl/rectangle_rc_lfsr.sv
// rectangle_rc_lfsr
//   5-bit round-constant register for the RECTANGLE key schedule.
//   Ports:
//     i_clk     - clock, updates on posedge
//     i_load    - reload the register with RC_INIT (has priority)
//     i_advance - step the LFSR by one round
//     ov_rc     - current round constant
module rectangle_rc_lfsr
  import rectangle_pkg::*;
#(
  parameter logic [rectangle_pkg::RW-1:0] RC_SEED = rectangle_pkg::RC_INIT
) (
  input  logic                         i_clk,
  input  logic                         i_load,
  input  logic                         i_advance,
  output logic [rectangle_pkg::RW-1:0] ov_rc
);

  logic [RW-1:0] rc_q;

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      rc_q <= RC_SEED;
    end else if (i_advance) begin
      rc_q <= rc_next(rc_q);
    end
  end

  assign ov_rc = rc_q;

endmodule

// File: rtl/rectangle_round_ctrl.sv
// rectangle_round_ctrl
//   Round sequencer for the RECTANGLE-128 core. Loads plaintext/key on start,
//   then selects round feedback for NUM_ROUNDS cycles, then strobes done for
//   one cycle. Back-to-back starts accepted in DONE.
//   Ports:
//     i_clk        - clock
//     i_rst        - synchronous active-high reset
//     i_start      - start request (ignored while busy)
//     o_select     - state-register mux: 0 load plaintext, 1 round feedback
//     o_key_select - key-register mux: 0 load user key, 1 key-schedule feedback
//     ov_round     - round index 0..NUM_ROUNDS-1 (0 outside ROUND)
//     ov_rc        - round constant for the current round
//     o_busy       - high in ROUND
//     o_done       - one-cycle strobe, ciphertext valid
module rectangle_round_ctrl #(
  parameter int unsigned             NUM_ROUNDS = rectangle_pkg::NUM_ROUNDS,
  parameter int unsigned             RW         = rectangle_pkg::RW,
  parameter logic [RW-1:0]           RC_INIT    = rectangle_pkg::RC_INIT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_select,
  output logic          o_key_select,
  output logic [RW-1:0] ov_round,
  output logic [RW-1:0] ov_rc,
  output logic          o_busy,
  output logic          o_done
);

  import rectangle_pkg::ST_IDLE;
  import rectangle_pkg::ST_ROUND;
  import rectangle_pkg::ST_DONE;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [RW-1:0] round_q;
  logic          in_round;
  logic          last_round;
  logic          rc_advance;
  logic          rc_load;

  assign in_round   = (state_q == ST_ROUND);
  assign last_round = in_round && (round_q == RW'(NUM_ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_ROUND;
      ST_ROUND: if (last_round) state_d = ST_DONE;
      ST_DONE:  state_d = i_start ? ST_ROUND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_round && !last_round) begin
        round_q <= round_q + 1'b1;
      end else begin
        round_q <= '0;
      end
    end
  end

  // The constant register is reloaded whenever it is not stepping, so it is
  // already at RC_INIT when ROUND is entered from IDLE or DONE; reset simply
  // forces a reload.
  assign rc_advance = in_round && !last_round;
  assign rc_load    = i_rst || !rc_advance;

  rectangle_rc_lfsr #(
    .RC_SEED (RC_INIT)
  ) u_rc_lfsr (
    .i_clk     (i_clk),
    .i_load    (rc_load),
    .i_advance (rc_advance),
    .ov_rc     (ov_rc)
  );

  assign o_select     = in_round;
  assign o_key_select = in_round;
  assign o_busy       = in_round;
  assign o_done       = (state_q == ST_DONE);
  assign ov_round     = round_q;

endmodule

// File: tb/tb_rectangle_round_ctrl.sv
// Testbench for rectangle_round_ctrl: behavioural model compared every cycle,
// plus directed literal checks on latency, round constants and control cases.
module tb_rectangle_round_ctrl;

  localparam int NR = 25;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       o_select, o_key_select, o_busy, o_done;
  logic [4:0] ov_round, ov_rc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Model: -1 idle, 0..NR-1 round index, NR done
  int m_k = -1;

  logic [4:0] rc_tab [NR] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                              5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                              5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                              5'h1B, 5'h17, 5'h0E, 5'h1D};

  int         done_q [$];
  logic [4:0] rc_q   [$];

  bit         e_busy, e_done;
  logic [4:0] e_round, e_rc;

  rectangle_round_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .o_select     (o_select),
    .o_key_select (o_key_select),
    .ov_round     (ov_round),
    .ov_rc        (ov_rc),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_rst) m_k <= -1;
    else if (m_k == -1) m_k <= i_start ? 0 : -1;
    else if (m_k < NR) m_k <= m_k + 1;
    else m_k <= i_start ? 0 : -1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = (m_k >= 0) && (m_k < NR);
      e_done  = (m_k == NR);
      e_round = e_busy ? 5'(m_k) : 5'd0;
      e_rc    = e_busy ? rc_tab[m_k] : 5'h01;
      chk("busy",       int'(o_busy),       int'(e_busy));
      chk("done",       int'(o_done),       int'(e_done));
      chk("select",     int'(o_select),     int'(e_busy));
      chk("key_select", int'(o_key_select), int'(e_busy));
      chk("round",      int'(ov_round),     int'(e_round));
      chk("rc",         int'(ov_rc),        int'(e_rc));
      if (o_done) done_q.push_back(cyc);
      if (o_busy) rc_q.push_back(ov_rc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int count, input int budget);
    for (int i = 0; i < budget && done_q.size() < count; i++) step();
  endtask

  initial begin
    int t;

    // Reset then idle
    i_rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    i_rst = 1'b0;
    step(10);
    chk("idle_rc_literal", int'(ov_rc), 5'h01);
    chk("idle_round_literal", int'(ov_round), 0);

    // Single encryption with round-constant capture
    done_q.delete();
    rc_q.delete();
    i_start = 1'b1;
    t = cyc;
    step();
    i_start = 1'b0;
    wait_done(1, 40);
    chk("single_done_count", done_q.size(), 1);
    if (done_q.size() >= 1) chk("single_done_cycle", done_q[0], t + 26);
    chk("rc_seq_len", rc_q.size(), NR);
    if (rc_q.size() == NR) begin
      chk("rc_round0",  int'(rc_q[0]),  5'h01);
      chk("rc_round3",  int'(rc_q[3]),  5'h09);
      chk("rc_round12", int'(rc_q[12]), 5'h0F);
      chk("rc_round24", int'(rc_q[24]), 5'h1D);
    end
    step(5);

    // Back-to-back with start held high
    done_q.delete();
    i_start = 1'b1;
    t = cyc;
    wait_done(3, 100);
    i_start = 1'b0;
    chk("b2b_done_count", done_q.size(), 3);
    if (done_q.size() >= 3) begin
      chk("b2b_done1", done_q[0], t + 26);
      chk("b2b_done2", done_q[1], t + 52);
      chk("b2b_done3", done_q[2], t + 78);
    end
    step(30);

    // Start pulses during rounds 3 and 24 are ignored
    done_q.delete();
    i_start = 1'b1;
    t = cyc;
    step();
    i_start = 1'b0;
    step(3);
    chk("ign_round3_literal", int'(ov_round), 3);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(20);
    chk("ign_round24_literal", int'(ov_round), 24);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(30);
    chk("ign_done_count", done_q.size(), 1);
    if (done_q.size() >= 1) chk("ign_done_cycle", done_q[0], t + 26);

    // Reset at round 12
    done_q.delete();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(12);
    chk("mid_round12_literal", int'(ov_round), 12);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst_busy",  int'(o_busy),   0);
    chk("mid_rst_round", int'(ov_round), 0);
    chk("mid_rst_rc",    int'(ov_rc),    5'h01);
    step(40);
    chk("mid_rst_no_done", done_q.size(), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
